sdlc_rx_frame_buf: RTL and testbench

- Downstream consumer of the sdlc receive path. Accepts 16-bit words on each rx_drq-style strobe, plus frame-end, abort and CRC-match status from the rx datapath.
- Buffers the words of the current frame in a local word FIFO.
- Commits a frame to the CPU/DMA read side only after it ends with a good CRC. Rolls the frame back on abort, CRC error, runt length or overflow.
- Gives firmware whole, validated frames plus error counters, instead of raw word strobes.

---
 rtl/sdlc_rx_frame_buf_pkg.sv | 21 ++
 rtl/sdlc_word_fifo_mem.sv | 24 ++
 rtl/sdlc_rx_frame_buf.sv | 137 +++++++++++++
 tb/tb_sdlc_rx_frame_buf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sdlc_rx_frame_buf_pkg.sv
// Shared types and helpers for the SDLC receive frame buffer.
package sdlc_rx_frame_buf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRecv,
    StDrop
  } rx_state_e;

  localparam logic [7:0] SDLC_FLAG = 8'h7E;

  // Pointer width: one extra bit over the address so full and empty differ.
  function automatic int unsigned ptr_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sdlc_word_fifo_mem.sv
// DEPTH x 16 word storage: one synchronous write port, one asynchronous read port.
module sdlc_word_fifo_mem #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sdlc_rx_frame_buf.sv
// Buffers received SDLC words per frame; exposes only frames that ended with a good CRC.
module sdlc_rx_frame_buf
  import sdlc_rx_frame_buf_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned MIN_WORDS = 2,
  parameter int unsigned STRIP_CRC = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] rx_word,
  input  logic        rx_valid,
  input  logic        rx_eof,
  input  logic        rx_crc_ok,
  input  logic        rx_abort,
  output logic [15:0] rd_data,
  output logic        rd_valid,
  input  logic        rd_ready,
  output logic        frame_done,
  output logic [7:0]  frame_len,
  output logic [7:0]  crc_err_cnt,
  output logic [7:0]  drop_cnt
);

  localparam int unsigned PW = ptr_w(DEPTH);
  localparam int unsigned AW = PW - 1;
  localparam logic [PW-1:0] DepthP = PW'(DEPTH);
  localparam logic [PW-1:0] StripP = PW'(STRIP_CRC);
  localparam logic [7:0]    StripL = 8'(STRIP_CRC);
  localparam logic [7:0]    MinL   = 8'(MIN_WORDS);

  rx_state_e     state_q;
  logic [PW-1:0] wr_ptr_q, cm_ptr_q, rd_ptr_q;
  logic [7:0]    len_q, frame_len_q, crc_err_q, drop_q;
  logic          frame_done_q;

  logic          full, frame_active, we;
  logic [PW-1:0] wr_nxt;
  logic [7:0]    len_nxt;

  assign full         = (wr_ptr_q - rd_ptr_q) == DepthP;
  assign rd_valid     = rd_ptr_q != cm_ptr_q;
  assign frame_active = (state_q == StRecv) || (state_q == StIdle && rx_valid);
  assign we           = frame_active && rx_valid && !full;
  assign wr_nxt       = rx_valid ? wr_ptr_q + PW'(1) : wr_ptr_q;

  always_comb begin
    len_nxt = len_q;
    if (state_q == StIdle) begin
      len_nxt = 8'd1;
    end else if (rx_valid && len_q != 8'hFF) begin
      len_nxt = len_q + 8'd1;
    end
  end

  sdlc_word_fifo_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .clk  (clk),
    .we   (we),
    .waddr(wr_ptr_q[AW-1:0]),
    .wdata(rx_word),
    .raddr(rd_ptr_q[AW-1:0]),
    .rdata(rd_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      cm_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      len_q        <= '0;
      frame_len_q  <= '0;
      crc_err_q    <= '0;
      drop_q       <= '0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (rd_valid && rd_ready) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      unique case (state_q)
        StIdle, StRecv: begin
          if (frame_active) begin
            if (rx_abort) begin
              wr_ptr_q <= cm_ptr_q;
              drop_q   <= sat_inc(drop_q);
              state_q  <= StIdle;
            end else if (rx_valid && full) begin
              drop_q <= sat_inc(drop_q);
              if (rx_eof) begin
                wr_ptr_q <= cm_ptr_q;
                state_q  <= StIdle;
              end else begin
                state_q <= StDrop;
              end
            end else begin
              wr_ptr_q <= wr_nxt;
              len_q    <= len_nxt;
              state_q  <= rx_eof ? StIdle : StRecv;
              if (rx_eof) begin
                if (!rx_crc_ok) begin
                  wr_ptr_q  <= cm_ptr_q;
                  crc_err_q <= sat_inc(crc_err_q);
                end else if (len_nxt < MinL) begin
                  wr_ptr_q <= cm_ptr_q;
                  drop_q   <= sat_inc(drop_q);
                end else begin
                  // The stripped CRC slot is released so the next frame overwrites it.
                  cm_ptr_q     <= wr_nxt - StripP;
                  wr_ptr_q     <= wr_nxt - StripP;
                  frame_len_q  <= len_nxt - StripL;
                  frame_done_q <= 1'b1;
                end
              end
            end
          end
        end
        StDrop: begin
          if (rx_eof || rx_abort) begin
            wr_ptr_q <= cm_ptr_q;
            state_q  <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign frame_done  = frame_done_q;
  assign frame_len   = frame_len_q;
  assign crc_err_cnt = crc_err_q;
  assign drop_cnt    = drop_q;

endmodule

// File: tb/tb_sdlc_rx_frame_buf.sv
// Directed self-checking bench for sdlc_rx_frame_buf (DEPTH=16, MIN_WORDS=2, STRIP_CRC=1).
module tb_sdlc_rx_frame_buf;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] rx_word = '0;
  logic        rx_valid = 1'b0, rx_eof = 1'b0, rx_crc_ok = 1'b0, rx_abort = 1'b0;
  logic        rd_ready = 1'b0;
  logic [15:0] rd_data;
  logic        rd_valid, frame_done;
  logic [7:0]  frame_len, crc_err_cnt, drop_cnt;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sdlc_rx_frame_buf #(
    .DEPTH    (16),
    .MIN_WORDS(2),
    .STRIP_CRC(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_word    (rx_word),
    .rx_valid   (rx_valid),
    .rx_eof     (rx_eof),
    .rx_crc_ok  (rx_crc_ok),
    .rx_abort   (rx_abort),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .frame_done (frame_done),
    .frame_len  (frame_len),
    .crc_err_cnt(crc_err_cnt),
    .drop_cnt   (drop_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] w, input logic eof, input logic ok);
    rx_word   = w;
    rx_valid  = 1'b1;
    rx_eof    = eof;
    rx_crc_ok = ok;
    cyc();
    rx_valid  = 1'b0;
    rx_eof    = 1'b0;
    rx_crc_ok = 1'b0;
  endtask

  task automatic end_frame(input logic ok);
    rx_eof    = 1'b1;
    rx_crc_ok = ok;
    cyc();
    rx_eof    = 1'b0;
    rx_crc_ok = 1'b0;
  endtask

  task automatic pop_chk(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, {15'd0, rd_valid}, 16'd1);
    chk(tag, rd_data, exp);
    rd_ready = 1'b1;
    cyc();
    rd_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    cyc();
    cyc();
    chk("rst_rd_valid", {15'd0, rd_valid}, 16'd0);
    chk("rst_frame_done", {15'd0, frame_done}, 16'd0);
    chk("rst_frame_len", {8'd0, frame_len}, 16'd0);
    chk("rst_crc_err", {8'd0, crc_err_cnt}, 16'd0);
    chk("rst_drop", {8'd0, drop_cnt}, 16'd0);
    reset = 1'b0;
    cyc();

    // Good frame, CRC word stripped
    send(16'h0015, 1'b0, 1'b0);
    send(16'h1B00, 1'b0, 1'b0);
    send(16'h0085, 1'b0, 1'b0);
    send(16'hE2F0, 1'b0, 1'b0);
    chk("good_precommit_valid", {15'd0, rd_valid}, 16'd0);
    end_frame(1'b1);
    chk("good_done", {15'd0, frame_done}, 16'd1);
    chk("good_len", {8'd0, frame_len}, 16'd3);
    chk("good_valid", {15'd0, rd_valid}, 16'd1);
    cyc();
    chk("good_done_pulse", {15'd0, frame_done}, 16'd0);
    pop_chk("good_w0", 16'h0015);
    pop_chk("good_w1", 16'h1B00);
    pop_chk("good_w2", 16'h0085);
    chk("good_empty", {15'd0, rd_valid}, 16'd0);

    // CRC error
    send(16'h0015, 1'b0, 1'b0);
    send(16'h1B00, 1'b0, 1'b0);
    send(16'h0085, 1'b0, 1'b0);
    send(16'hE2F0, 1'b0, 1'b0);
    end_frame(1'b0);
    chk("crc_done", {15'd0, frame_done}, 16'd0);
    chk("crc_valid", {15'd0, rd_valid}, 16'd0);
    chk("crc_cnt", {8'd0, crc_err_cnt}, 16'd1);
    cyc();
    chk("crc_valid_later", {15'd0, rd_valid}, 16'd0);

    // Abort, then a good frame; stale words from either dropped frame must not appear
    send(16'hAAA1, 1'b0, 1'b0);
    send(16'hAAA2, 1'b0, 1'b0);
    rx_abort = 1'b1;
    cyc();
    rx_abort = 1'b0;
    chk("abort_drop", {8'd0, drop_cnt}, 16'd1);
    chk("abort_valid", {15'd0, rd_valid}, 16'd0);
    send(16'h1111, 1'b0, 1'b0);
    send(16'h2222, 1'b0, 1'b0);
    send(16'hCCCC, 1'b0, 1'b0);
    end_frame(1'b1);
    chk("abort2_done", {15'd0, frame_done}, 16'd1);
    chk("abort2_len", {8'd0, frame_len}, 16'd2);
    pop_chk("abort2_w0", 16'h1111);
    pop_chk("abort2_w1", 16'h2222);
    chk("abort2_empty", {15'd0, rd_valid}, 16'd0);

    // Overflow from empty: word 17 triggers the drop
    for (int i = 0; i < 16; i++) send(16'h3000 + 16'(i), 1'b0, 1'b0);
    chk("ovf_drop_w16", {8'd0, drop_cnt}, 16'd1);
    send(16'h3010, 1'b0, 1'b0);
    chk("ovf_drop_w17", {8'd0, drop_cnt}, 16'd2);
    for (int i = 17; i < 20; i++) send(16'h3000 + 16'(i), 1'b0, 1'b0);
    end_frame(1'b1);
    chk("ovf_done", {15'd0, frame_done}, 16'd0);
    chk("ovf_valid", {15'd0, rd_valid}, 16'd0);
    chk("ovf_drop_once", {8'd0, drop_cnt}, 16'd2);

    // Overflow behind an unread committed frame leaves it intact
    send(16'h5A01, 1'b0, 1'b0);
    send(16'h5A02, 1'b0, 1'b0);
    send(16'h5ACC, 1'b0, 1'b0);
    end_frame(1'b1);
    for (int i = 0; i < 20; i++) send(16'h7000 + 16'(i), 1'b0, 1'b0);
    end_frame(1'b1);
    chk("ovf2_drop", {8'd0, drop_cnt}, 16'd3);
    chk("ovf2_len", {8'd0, frame_len}, 16'd2);
    pop_chk("ovf2_w0", 16'h5A01);
    pop_chk("ovf2_w1", 16'h5A02);
    chk("ovf2_empty", {15'd0, rd_valid}, 16'd0);

    // Runt
    send(16'h9999, 1'b0, 1'b0);
    end_frame(1'b1);
    chk("runt_drop", {8'd0, drop_cnt}, 16'd4);
    chk("runt_done", {15'd0, frame_done}, 16'd0);
    chk("runt_valid", {15'd0, rd_valid}, 16'd0);

    // Last word and eof in the same cycle
    send(16'h4401, 1'b0, 1'b0);
    send(16'h4402, 1'b0, 1'b0);
    send(16'h4403, 1'b0, 1'b0);
    send(16'h44CC, 1'b1, 1'b1);
    chk("same_done", {15'd0, frame_done}, 16'd1);
    chk("same_len", {8'd0, frame_len}, 16'd3);
    pop_chk("same_w0", 16'h4401);
    pop_chk("same_w1", 16'h4402);
    pop_chk("same_w2", 16'h4403);
    chk("same_empty", {15'd0, rd_valid}, 16'd0);

    // Reset mid-frame with one committed frame unread
    send(16'h6601, 1'b0, 1'b0);
    send(16'h6602, 1'b0, 1'b0);
    send(16'h66CC, 1'b0, 1'b0);
    end_frame(1'b1);
    send(16'h6701, 1'b0, 1'b0);
    send(16'h6702, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("mrst_valid", {15'd0, rd_valid}, 16'd0);
    chk("mrst_len", {8'd0, frame_len}, 16'd0);
    chk("mrst_crc", {8'd0, crc_err_cnt}, 16'd0);
    chk("mrst_drop", {8'd0, drop_cnt}, 16'd0);
    chk("mrst_done", {15'd0, frame_done}, 16'd0);
    cyc();
    reset = 1'b0;
    cyc();
    send(16'h8801, 1'b0, 1'b0);
    send(16'h8802, 1'b0, 1'b0);
    send(16'h88CC, 1'b0, 1'b0);
    end_frame(1'b1);
    chk("post_len", {8'd0, frame_len}, 16'd2);
    pop_chk("post_w0", 16'h8801);
    pop_chk("post_w1", 16'h8802);
    chk("post_empty", {15'd0, rd_valid}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
